// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request/result handshake bundle between the decode stage and alu_issue_ctrl.
// Optional err signal exists only when ALU_OPCODE_ERR_EN is defined.
`default_nettype none

interface alu_issue_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [10:0]      in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             res_zero;
`ifdef ALU_OPCODE_ERR_EN
  logic             err;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, result, res_zero, err
  );
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, result, res_zero, err
  );
`else
  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, result, res_zero
  );
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, result, res_zero
  );
`endif
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes a LEGv8 opcode, drives registered operands/control into the ALU and
// returns the captured result. Optional illegal-opcode flag under ALU_OPCODE_ERR_EN.
`default_nettype none

module alu_issue_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] src1,
  output logic [WIDTH-1:0] src2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_output,
  input  logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_alive;
  logic             w_in_ready;
  logic             w_accept;
  logic [3:0]       w_dec_ctrl;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_src2;
  logic [3:0]       r_alu_ctrl;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_res_zero;
`ifdef ALU_OPCODE_ERR_EN
  logic             w_dec_legal;
  logic             r_illegal;
  logic             r_err;
`endif

  // r_alive keeps in_ready low until the first edge after reset is released.
  assign w_in_ready = (r_state == IDLE) && r_alive;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_dec_ctrl = 4'b0010;
`ifdef ALU_OPCODE_ERR_EN
    w_dec_legal = 1'b1;
`endif
    casez (bus.in_opcode)
      11'b10001011000: w_dec_ctrl = 4'b0010;
      11'b11001011000: w_dec_ctrl = 4'b0110;
      11'b10001010000: w_dec_ctrl = 4'b0000;
      11'b10101010000: w_dec_ctrl = 4'b0001;
      11'b11111000010,
      11'b11111000000: w_dec_ctrl = 4'b0010;
      11'b10110100???: w_dec_ctrl = 4'b0111;
      11'b11101010000: w_dec_ctrl = 4'b1100;
      default: begin
        w_dec_ctrl = 4'b0010;
`ifdef ALU_OPCODE_ERR_EN
        w_dec_legal = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src1      <= '0;
      r_src2      <= '0;
      r_alu_ctrl  <= 4'b0000;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_res_zero  <= 1'b0;
`ifdef ALU_OPCODE_ERR_EN
      r_illegal   <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_src1     <= bus.in_a;
        r_src2     <= bus.in_b;
        r_alu_ctrl <= w_dec_ctrl;
`ifdef ALU_OPCODE_ERR_EN
        r_illegal  <= ~w_dec_legal;
`endif
      end
      // The ALU has had a full cycle on the registered operands; capture now.
      if (r_state == EXEC) begin
        r_out_valid <= 1'b1;
`ifdef ALU_OPCODE_ERR_EN
        r_err      <= r_illegal;
        r_result   <= r_illegal ? '0 : alu_output;
        r_res_zero <= r_illegal ? 1'b0 : zero;
`else
        r_result   <= alu_output;
        r_res_zero <= zero;
`endif
      end
      if ((r_state == DONE) && bus.out_ready) begin
        r_out_valid <= 1'b0;
`ifdef ALU_OPCODE_ERR_EN
        r_err       <= 1'b0;
`endif
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.res_zero  = r_res_zero;
`ifdef ALU_OPCODE_ERR_EN
  assign bus.err       = r_err;
`endif
  assign src1          = r_src1;
  assign src2          = r_src2;
  assign alu_ctrl      = r_alu_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench for alu_issue_ctrl with a behavioural ALU.
`default_nettype none

module tb_alu_issue_ctrl;
  localparam int WIDTH = 64;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_NOR  = 11'b11101010000;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] src1, src2, alu_output;
  logic [3:0]       alu_ctrl;
  logic             zero;
  int               n_checks;
  int               n_fail;

  alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .src1       (src1),
    .src2       (src2),
    .alu_ctrl   (alu_ctrl),
    .alu_output (alu_output),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU
  always_comb begin
    alu_output = '0;
    case (alu_ctrl)
      4'b0010: alu_output = src1 + src2;
      4'b0110: alu_output = src1 - src2;
      4'b0000: alu_output = src1 & src2;
      4'b0001: alu_output = src1 | src2;
      4'b0111: alu_output = src2;
      4'b1100: alu_output = ~(src1 | src2);
      default: alu_output = '0;
    endcase
    zero = (alu_output == '0);
  end

  // Present one request at a negedge; returns at the following negedge (EXEC if accepted).
  task automatic run_op(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (src1 !== 64'd0 || src2 !== 64'd0) begin n_fail++; $display("FAIL rst_src got %h/%h exp 0/0", src1, src2); end
    n_checks++; if (alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL rst_alu_ctrl got %b exp 0000", alu_ctrl); end
    n_checks++; if (bus.result !== 64'd0 || bus.res_zero !== 1'b0) begin n_fail++; $display("FAIL rst_result got %h/%b exp 0/0", bus.result, bus.res_zero); end
`ifdef ALU_OPCODE_ERR_EN
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", bus.err); end
`endif
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready got %b exp 0", bus.in_ready); end
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b exp 1", bus.in_ready); end
    // Reset in the middle of EXEC discards the operation
    bus.out_ready = 1'b1;
    run_op(OP_ADD, 64'd5, 64'd7);
    n_checks++; if (src1 !== 64'd5) begin n_fail++; $display("FAIL exec_src1 got %h exp 5", src1); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midexec_rst got ov=%b rdy=%b exp 0/0", bus.out_valid, bus.in_ready); end
    n_checks++; if (src1 !== 64'd0) begin n_fail++; $display("FAIL midexec_src1 got %h exp 0", src1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midexec_recover got rdy=%b ov=%b exp 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_add;
    bus.out_ready = 1'b1;
    run_op(OP_ADD, 64'd5, 64'd7);
    n_checks++; if (alu_ctrl !== 4'b0010) begin n_fail++; $display("FAIL add_ctrl got %b exp 0010", alu_ctrl); end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL add_exec got ov=%b rdy=%b exp 0/0", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency got ov=%b exp 1", bus.out_valid); end
    n_checks++; if (bus.result !== 64'd12 || bus.res_zero !== 1'b0) begin n_fail++; $display("FAIL add_result got %h/%b exp c/0", bus.result, bus.res_zero); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_pulse got ov=%b rdy=%b exp 0/1", bus.out_valid, bus.in_ready); end
    run_op(OP_LDUR, 64'h100, 64'h8);
    n_checks++; if (alu_ctrl !== 4'b0010) begin n_fail++; $display("FAIL ldur_ctrl got %b exp 0010", alu_ctrl); end
    repeat (2) @(negedge clk);
    run_op(OP_STUR, 64'h100, 64'h10);
    n_checks++; if (alu_ctrl !== 4'b0010) begin n_fail++; $display("FAIL stur_ctrl got %b exp 0010", alu_ctrl); end
    @(negedge clk);
    n_checks++; if (bus.result !== 64'h110) begin n_fail++; $display("FAIL stur_result got %h exp 110", bus.result); end
    @(negedge clk);
  endtask

  task automatic test_sub;
    bus.out_ready = 1'b1;
    run_op(OP_SUB, 64'h1234, 64'h1234);
    n_checks++; if (alu_ctrl !== 4'b0110) begin n_fail++; $display("FAIL sub_ctrl got %b exp 0110", alu_ctrl); end
    @(negedge clk);
    n_checks++; if (bus.result !== 64'd0 || bus.res_zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero got %h/%b exp 0/1", bus.result, bus.res_zero); end
    @(negedge clk);
    run_op(OP_SUB, 64'd0, 64'd1);
    @(negedge clk);
    n_checks++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFF || bus.res_zero !== 1'b0) begin n_fail++; $display("FAIL sub_wrap got %h/%b exp ffffffffffffffff/0", bus.result, bus.res_zero); end
    @(negedge clk);
  endtask

  task automatic test_cbz_backpressure;
    bus.out_ready = 1'b0;
    run_op(OP_CBZ, 64'd5, 64'd0);
    n_checks++; if (alu_ctrl !== 4'b0111) begin n_fail++; $display("FAIL cbz_ctrl got %b exp 0111", alu_ctrl); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.in_opcode = OP_ADD;
        bus.in_a      = 64'd99;
        bus.in_b      = 64'd1;
        bus.in_valid  = 1'b1;
      end
      n_checks++; if (bus.out_valid !== 1'b1 || bus.result !== 64'd0 || bus.res_zero !== 1'b1) begin n_fail++; $display("FAIL cbz_hold[%0d] got ov=%b res=%h z=%b exp 1/0/1", i, bus.out_valid, bus.result, bus.res_zero); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL cbz_ready[%0d] got %b exp 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL cbz_cycle6 got ov=%b exp 1", bus.out_valid); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL cbz_release got ov=%b rdy=%b exp 0/1", bus.out_valid, bus.in_ready); end
    n_checks++; if (src1 !== 64'd5 || alu_ctrl !== 4'b0111) begin n_fail++; $display("FAIL cbz_nocapture got src1=%h ctrl=%b exp 5/0111", src1, alu_ctrl); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] ops [3];
    logic [63:0] as  [3];
    logic [63:0] bs  [3];
    logic [63:0] exp_res [3];
    ops = '{OP_AND, OP_ORR, OP_NOR};
    as  = '{64'hF0, 64'hF0, 64'h0};
    bs  = '{64'h3C, 64'h0F, 64'h0};
    exp_res = '{64'h30, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.in_opcode = ops[c/3];
      bus.in_a      = as[c/3];
      bus.in_b      = bs[c/3];
      #1;
      n_checks++; if (bus.in_ready !== ((c % 3) == 0)) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b exp %b", c, bus.in_ready, ((c % 3) == 0)); end
      if ((c % 3) == 2) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.result !== exp_res[c/3] || bus.res_zero !== 1'b0) begin n_fail++; $display("FAIL b2b_result[%0d] got ov=%b %h z=%b exp 1 %h 0", c, bus.out_valid, bus.result, bus.res_zero, exp_res[c/3]); end
      end else begin
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ov[%0d] got %b exp 0", c, bus.out_valid); end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++; if (alu_ctrl !== 4'b1100) begin n_fail++; $display("FAIL b2b_nor_ctrl got %b exp 1100", alu_ctrl); end
  endtask

  task automatic test_illegal;
    bus.out_ready = 1'b1;
    run_op(11'b00000000000, 64'd1, 64'd2);
    n_checks++; if (alu_ctrl !== 4'b0010) begin n_fail++; $display("FAIL ill_ctrl got %b exp 0010", alu_ctrl); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_ov got %b exp 1", bus.out_valid); end
`ifdef ALU_OPCODE_ERR_EN
    n_checks++; if (bus.err !== 1'b1 || bus.result !== 64'd0 || bus.res_zero !== 1'b0) begin n_fail++; $display("FAIL ill_err got err=%b res=%h z=%b exp 1/0/0", bus.err, bus.result, bus.res_zero); end
`else
    n_checks++; if (bus.result !== 64'd3 || bus.res_zero !== 1'b0) begin n_fail++; $display("FAIL ill_add got %h/%b exp 3/0", bus.result, bus.res_zero); end
`endif
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_clear got ov=%b exp 0", bus.out_valid); end
`ifdef ALU_OPCODE_ERR_EN
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ill_err_clear got %b exp 0", bus.err); end
`endif
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_cbz_backpressure();
    test_back_to_back();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
